wb_arbiter_wdt: RTL and testbench

Round-robin Wishbone arbiter with a per-transfer watchdog, sharing one slave port between `num_masters` masters. The watchdog terminates any transfer the slave fails to answer within `timeout` cycles: it returns `err` to the stalled master and briefly deasserts slave `cyc`. A dead or misdecoded slave therefore cannot lock the bus. The block sits between CPU/DMA masters and a shared peripheral bus, in place of the plain arbiter where bus liveness matters.

---
 rtl/wb_arbiter_wdt.sv | 91 +++++++++
 tb/tb_wb_arbiter_wdt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_wdt.sv
// wb_arbiter_wdt: round-robin Wishbone arbiter sharing one slave port, with a
// per-transfer watchdog that aborts stalled transfers with err to the owner.
module wb_arbiter_wdt #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int num_masters = 2,
  parameter int timeout = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [num_masters*aw-1:0] wbm_adr_i,
  input  logic [num_masters*dw-1:0] wbm_dat_i,
  input  logic [num_masters*4-1:0]  wbm_sel_i,
  input  logic [num_masters-1:0]    wbm_we_i,
  input  logic [num_masters-1:0]    wbm_cyc_i,
  input  logic [num_masters-1:0]    wbm_stb_i,
  input  logic [num_masters*3-1:0]  wbm_cti_i,
  input  logic [num_masters*2-1:0]  wbm_bte_i,
  output logic [num_masters*dw-1:0] wbm_dat_o,
  output logic [num_masters-1:0]    wbm_ack_o,
  output logic [num_masters-1:0]    wbm_err_o,
  output logic [num_masters-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [num_masters-1:0]    grant_o,
  output logic                      timeout_o
);
  localparam int sw = num_masters > 1 ? $clog2(num_masters) : 1;
  localparam int cw = timeout > 0 ? $clog2(timeout + 1) : 1;
  localparam logic [1:0] s_idle = 2'd0, s_grant = 2'd1, s_abort = 2'd2;
  logic [1:0] state;
  logic [sw-1:0] sel, last, nxt, idx;
  logic [cw-1:0] cnt;
  logic [num_masters-1:0] oh;
  logic g, a, stall, trip;
  // Descending scan so the nearest requester after last is the final assignment.
  always_comb begin
    nxt = last;
    idx = '0;
    for (int i = num_masters; i >= 1; i--) begin
      idx = sw'((int'(last) + i) % num_masters);
      if (wbm_cyc_i[idx]) nxt = idx;
    end
  end
  assign g = state == s_grant;
  assign a = state == s_abort;
  assign oh = num_masters'(1) << sel;
  assign stall = g & wbm_cyc_i[sel] & wbm_stb_i[sel] & ~wbs_ack_i & ~wbs_err_i & ~wbs_rty_i;
  assign trip = timeout > 0 && stall && cnt == cw'(timeout - 1);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= s_idle;
      sel <= '0;
      last <= sw'(num_masters - 1);
      cnt <= '0;
    end else begin
      cnt <= (timeout > 0 && stall && !trip) ? cnt + 1'b1 : '0;
      if (state == s_idle && |wbm_cyc_i) begin
        state <= s_grant;
        sel <= nxt;
        last <= nxt;
      end else if (g)
        state <= !wbm_cyc_i[sel] ? s_idle : trip ? s_abort : s_grant;
      else if (a)
        state <= wbm_cyc_i[sel] ? s_grant : s_idle;
    end
  assign wbs_adr_o = wbm_adr_i[sel*aw +: aw];
  assign wbs_dat_o = wbm_dat_i[sel*dw +: dw];
  assign wbs_sel_o = wbm_sel_i[sel*4 +: 4];
  assign wbs_we_o  = wbm_we_i[sel];
  assign wbs_cti_o = wbm_cti_i[sel*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[sel*2 +: 2];
  assign wbs_cyc_o = g & wbm_cyc_i[sel];
  assign wbs_stb_o = g & wbm_stb_i[sel];
  assign wbm_dat_o = {num_masters{wbs_dat_i}};
  assign wbm_ack_o = (g && wbs_ack_i) ? oh : '0;
  assign wbm_rty_o = (g && wbs_rty_i) ? oh : '0;
  assign wbm_err_o = (a || (g && wbs_err_i)) ? oh : '0;
  assign grant_o   = g ? oh : '0;
  assign timeout_o = a;
endmodule

// File: tb/tb_wb_arbiter_wdt.sv
// tb_wb_arbiter_wdt: scoreboard bench for the round-robin arbiter and watchdog.
module tb_wb_arbiter_wdt;
  localparam int nm = 3;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [nm*32-1:0] adr, dat, m_dat;
  logic [nm*4-1:0] msel;
  logic [nm-1:0] we, cyc, stb, m_ack, m_err, m_rty, grant;
  logic [nm*3-1:0] cti;
  logic [nm*2-1:0] bte;
  logic [31:0] s_adr, s_dat, s_rdat;
  logic [3:0] s_sel;
  logic s_we, s_cyc, s_stb, tmo;
  logic s_ack = 0, s_err = 0, s_rty = 0;
  logic [2:0] s_cti;
  logic [1:0] s_bte;
  logic [63:0] b_mdat;
  logic [1:0] b_cyc = 0, b_stb = 0, b_ack, b_err, b_rty, b_grant, b_bte;
  logic [31:0] b_adr, b_dat;
  logic [3:0] b_sel;
  logic [2:0] b_cti;
  logic b_we, b_scyc, b_sstb, b_tmo;
  int n_cmp = 0, n_bad = 0;
  logic [34:0] q[$];
  logic [34:0] e;

  wb_arbiter_wdt #(.dw(32), .aw(32), .num_masters(nm), .timeout(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(msel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(m_dat), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant), .timeout_o(tmo)
  );

  wb_arbiter_wdt #(.dw(32), .aw(32), .num_masters(2), .timeout(0)) dut_off (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(64'h0), .wbm_dat_i(64'h0), .wbm_sel_i(8'hff), .wbm_we_i(2'b00),
    .wbm_cyc_i(b_cyc), .wbm_stb_i(b_stb), .wbm_cti_i(6'h0), .wbm_bte_i(4'h0),
    .wbm_dat_o(b_mdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
    .wbs_adr_o(b_adr), .wbs_dat_o(b_dat), .wbs_sel_o(b_sel), .wbs_we_o(b_we),
    .wbs_cyc_o(b_scyc), .wbs_stb_o(b_sstb), .wbs_cti_o(b_cti), .wbs_bte_o(b_bte),
    .wbs_dat_i(32'h0), .wbs_ack_i(1'b0), .wbs_err_i(1'b0), .wbs_rty_i(1'b0),
    .grant_o(b_grant), .timeout_o(b_tmo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ack reaching a master must match the oldest expected {owner, data}.
  always @(negedge clk)
    if (!rst && |m_ack) begin
      if (q.size() == 0) check("sb_extra", {61'd0, m_ack}, 64'd0);
      else begin
        e = q.pop_front();
        check("sb", {29'd0, m_ack, m_dat[31:0]}, {29'd0, e});
      end
    end

  initial begin
    adr = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    dat = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    msel = '1; we = 0; cyc = 0; stb = 0; cti = 0; bte = 0; s_rdat = 0;
    repeat (2) tick();
    check("rst_grant", grant, 0);
    check("rst_cyc", s_cyc, 0);
    check("rst_ack", m_ack, 0);
    check("rst_tmo", tmo, 0);
    check("rst_adr", s_adr, 32'hA000_0000);
    rst = 0;
    tick();
    cyc[0] = 1; stb[0] = 1; cti[2:0] = 3'b010;
    #1;
    check("idle_cyc", s_cyc, 0);
    tick();
    check("g0_grant", grant, 3'b001);
    check("g0_cyc", s_cyc, 1);
    check("g0_cti", s_cti, 3'b010);
    s_ack = 1; s_rdat = 32'h1234;
    #1;
    check("pre_rst_ack", m_ack, 3'b001);
    rst = 1;
    #1;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_cyc", s_cyc, 0);
    check("rst_mid_ack", m_ack, 0);
    s_ack = 0; cyc = 0; stb = 0; cti = 0;
    tick();
    rst = 0;
    tick();
    cyc = 3'b011; stb = 3'b011;
    tick();
    check("first_win", grant, 3'b001);
    cyc = 3'b111; stb = 3'b111;
    for (int r = 0; r < 4; r++) begin
      automatic int m = r % 3;
      check("rr_grant", grant, 3'b1 << m);
      check("rr_adr", s_adr, 32'hA000_0000 + m);
      repeat (2) begin
        s_ack = 1; s_rdat = $urandom;
        q.push_back({3'b1 << m, s_rdat});
        tick();
      end
      s_ack = 0; cyc[m] = 0; stb[m] = 0;
      #1;
      check("rr_drop", s_cyc, 0);
      tick();
      check("rr_gap", grant, 0);
      check("rr_gap_cyc", s_cyc, 0);
      cyc[m] = 1; stb[m] = 1;
      tick();
    end
    cyc = 0; stb = 0;
    repeat (2) tick();
    cyc = 3'b010; stb = 3'b010;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wd_stall_cyc", s_cyc, 1);
      check("wd_stall_err", m_err, 0);
      check("wd_stall_tmo", tmo, 0);
      tick();
    end
    check("wd_err", m_err, 3'b010);
    check("wd_tmo", tmo, 1);
    check("wd_cyc", s_cyc, 0);
    check("wd_grant", grant, 0);
    s_ack = 1;
    #1;
    check("late_ack", m_ack, 0);
    s_ack = 0;
    tick();
    check("wd_regrant_cyc", s_cyc, 1);
    check("wd_regrant", grant, 3'b010);
    check("wd_regrant_err", m_err, 0);
    repeat (3) tick();
    s_ack = 1; s_rdat = $urandom;
    q.push_back({3'b010, s_rdat});
    #1;
    check("bnd_err", m_err, 0);
    check("bnd_tmo", tmo, 0);
    tick();
    s_ack = 0;
    for (int i = 0; i < 4; i++) begin
      check("bnd_restart", tmo, 0);
      tick();
    end
    check("bnd_abort", tmo, 1);
    tick();
    repeat (2) tick();
    stb[1] = 0;
    tick();
    stb[1] = 1;
    for (int i = 0; i < 4; i++) begin
      check("stb_restart", tmo, 0);
      tick();
    end
    check("stb_abort", tmo, 1);
    cyc = 0; stb = 0;
    repeat (2) tick();
    b_cyc = 2'b01; b_stb = 2'b01;
    tick();
    begin
      automatic int n_to = 0, n_low = 0;
      repeat (1000) begin
        if (b_tmo || |b_err) n_to++;
        if (!b_scyc) n_low++;
        tick();
      end
      check("wdt_off_abort", n_to, 0);
      check("wdt_off_cyc", n_low, 0);
    end
    check("wdt_off_grant", b_grant, 2'b01);
    b_cyc = 0; b_stb = 0;
    tick();
    check("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
